// File: rtl/noc_output_link_scheduler_pkg.sv
// Shared types and defaults for the router output-link scheduler.
package noc_output_link_scheduler_pkg;

    localparam int Noc_VC_Channel   = 4;
    localparam int Noc_link_credits = 4;

    typedef enum logic {
        SCHED_IDLE,
        SCHED_LOCKED
    } noc_sched_state_e;

endpackage

// File: rtl/noc_output_link_scheduler_if.sv
// VC FIFO / link-side signal bundle between the port control and the scheduler.
interface noc_output_link_scheduler_if
    import noc_output_link_scheduler_pkg::*;
#(
    parameter int CHANNELS = Noc_VC_Channel,
    parameter int CW       = $clog2(Noc_link_credits + 1)
);

    logic [CHANNELS-1:0]    vc_valid;
    logic [CHANNELS-1:0]    vc_sop;
    logic [CHANNELS-1:0]    vc_eop;
    logic [CHANNELS-1:0]    credit_return;
    logic [CHANNELS-1:0]    vc_pop;
    logic                   link_valid;
    logic [CHANNELS-1:0]    link_vc;
    logic [CHANNELS*CW-1:0] credit_count;
    logic                   locked;
    logic                   proto_err;

    modport master (
        output vc_valid, vc_sop, vc_eop, credit_return,
        input  vc_pop, link_valid, link_vc, credit_count, locked, proto_err
    );

    modport slave (
        input  vc_valid, vc_sop, vc_eop, credit_return,
        output vc_pop, link_valid, link_vc, credit_count, locked, proto_err
    );

endinterface

// File: rtl/noc_output_link_scheduler_credit_counter.sv
// Per-VC downstream credit counter; saturates at CREDITS and flags an excess return.
module noc_output_link_scheduler_credit_counter
    import noc_output_link_scheduler_pkg::*;
#(
    parameter int CREDITS = Noc_link_credits,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          noc_clk,
    input  logic          noc_rst_n,
    input  logic          dec_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic          nonzero_o,
    output logic          overflow_err_o
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d        = count_q;
        overflow_err_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == FULL) begin
                overflow_err_o = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/noc_output_link_scheduler.sv
// Packet-granular output-link scheduler: credit tracking, head-to-tail VC lock,
// and round-robin selection between VCs at packet boundaries.
module noc_output_link_scheduler
    import noc_output_link_scheduler_pkg::*;
#(
    parameter  int CHANNELS = Noc_VC_Channel,
    parameter  int CREDITS  = Noc_link_credits,
    localparam int CW       = $clog2(CREDITS + 1)
) (
    input  logic                         noc_clk,
    input  logic                         noc_rst_n,
    noc_output_link_scheduler_if.slave   bus
);

    function automatic logic [CHANNELS-1:0] rotate1(input logic [CHANNELS-1:0] v);
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            r[(i + 1) % CHANNELS] = v[i];
        end
        return r;
    endfunction

    // First request at or after the one-hot pointer, scanning a doubled vector to wrap.
    function automatic logic [CHANNELS-1:0] rr_pick(input logic [CHANNELS-1:0] req,
                                                    input logic [CHANNELS-1:0] ptr);
        logic [2*CHANNELS-1:0] dbl;
        logic [CHANNELS-1:0]   grant;
        logic                  found;
        int                    base;
        dbl   = {req, req};
        grant = '0;
        found = 1'b0;
        base  = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ptr[i]) base = i;
        end
        for (int i = 0; i < 2 * CHANNELS; i++) begin
            if (!found && i >= base && dbl[i]) begin
                grant[i % CHANNELS] = 1'b1;
                found               = 1'b1;
            end
        end
        return grant;
    endfunction

    noc_sched_state_e           state_q, state_d;
    logic [CHANNELS-1:0]        owner_q, owner_d;
    logic [CHANNELS-1:0]        rr_q, rr_d;
    logic [CHANNELS-1:0]        pop;
    logic [CHANNELS-1:0]        cand;
    logic [CHANNELS-1:0]        eligible;
    logic [CHANNELS-1:0]        nonzero;
    logic [CHANNELS-1:0]        ovf;
    logic [CHANNELS-1:0][CW-1:0] count;
    logic                       proto_err_d;
    logic                       link_valid_q;
    logic [CHANNELS-1:0]        link_vc_q;
    logic                       locked_q;
    logic                       proto_err_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_credit
        noc_output_link_scheduler_credit_counter #(
            .CREDITS (CREDITS),
            .CW      (CW)
        ) u_cnt (
            .noc_clk        (noc_clk),
            .noc_rst_n      (noc_rst_n),
            .dec_i          (pop[g]),
            .inc_i          (bus.credit_return[g]),
            .count_o        (count[g]),
            .nonzero_o      (nonzero[g]),
            .overflow_err_o (ovf[g])
        );
    end

    assign eligible = bus.vc_valid & nonzero;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        pop         = '0;
        cand        = eligible & bus.vc_sop;
        proto_err_d = |ovf;
        case (state_q)
            SCHED_IDLE: begin
                pop = rr_pick(cand, rr_q);
                // A non-head flit at a FIFO head outside a packet is a framing error.
                if (|(bus.vc_valid & ~bus.vc_sop)) proto_err_d = 1'b1;
                if (|pop) begin
                    if (|(pop & bus.vc_eop)) begin
                        rr_d = rotate1(pop);
                    end else begin
                        state_d = SCHED_LOCKED;
                        owner_d = pop;
                    end
                end
            end
            SCHED_LOCKED: begin
                pop = owner_q & eligible;
                if (|pop) begin
                    if (|(pop & bus.vc_sop)) proto_err_d = 1'b1;
                    if (|(pop & bus.vc_eop)) begin
                        state_d = SCHED_IDLE;
                        rr_d    = rotate1(owner_q);
                    end
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q      <= SCHED_IDLE;
            owner_q      <= '0;
            rr_q         <= CHANNELS'(1);
            link_valid_q <= 1'b0;
            link_vc_q    <= '0;
            locked_q     <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            link_valid_q <= |pop;
            link_vc_q    <= pop;
            locked_q     <= (state_d == SCHED_LOCKED);
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.vc_pop       = pop;
    assign bus.link_valid   = link_valid_q;
    assign bus.link_vc      = link_vc_q;
    assign bus.credit_count = count;
    assign bus.locked       = locked_q;
    assign bus.proto_err    = proto_err_q;

endmodule
